// File: rtl/header_overlay.sv
// rtl/header_overlay.sv - scaled 12x120 header text box overlay, 2-cycle pixel pipeline
// Optional frame blink of the text box under macro OVERLAY_BLINK_EN.
module header_overlay #(
  parameter int X0         = 160,
  parameter int Y0         = 16,
  parameter int SCALE_LOG2 = 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          frame_start,
  input  logic [1439:0] pixel_map,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          pixel_valid,
  output logic          text_on,
  output logic          text_valid
);

  localparam logic [11:0] BOX_W = 12'(120 << SCALE_LOG2);
  localparam logic [11:0] BOX_H = 12'(12 << SCALE_LOG2);
  localparam logic [10:0] X0_W  = 11'(X0);
  localparam logic [10:0] Y0_W  = 11'(Y0);

  logic [1439:0] shadow;
  logic [10:0]   dx, dy;
  logic          in_box_d;
  logic [6:0]    c_d;
  logic [3:0]    r_d;
  logic [6:0]    c_q;
  logic [3:0]    r_q;
  logic          in_box_q;
  logic          pixel_valid_q;
  logic [10:0]   row_base;
  logic [10:0]   bit_idx;
  logic          vis;
  logic          text_on_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow <= '0;
    end else if (frame_start) begin
      shadow <= pixel_map;
    end
  end

`ifdef OVERLAY_BLINK_EN
  logic [5:0] blink_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_cnt <= '0;
    end else if (frame_start) begin
      blink_cnt <= blink_cnt + 6'd1;
    end
  end

  assign vis = ~blink_cnt[5];
`else
  assign vis = 1'b1;
`endif

  // Negative offsets show up as bit 10 set; the box test is then done unsigned.
  assign dx = {1'b0, DrawX} - X0_W;
  assign dy = {1'b0, DrawY} - Y0_W;

  always_comb begin
    in_box_d = pixel_valid & ~dx[10] & ({1'b0, dx} < BOX_W)
                           & ~dy[10] & ({1'b0, dy} < BOX_H);
    c_d = '0;
    r_d = '0;
    if (in_box_d) begin
      c_d = 7'(dx >> SCALE_LOG2);
      r_d = 4'(dy >> SCALE_LOG2);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      c_q           <= '0;
      r_q           <= '0;
      in_box_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      c_q           <= c_d;
      r_q           <= r_d;
      in_box_q      <= in_box_d;
      pixel_valid_q <= pixel_valid;
    end
  end

  // Row 0, column 0 is the MSB of the map.
  always_comb begin
    row_base  = 11'(r_q) * 11'd120;
    bit_idx   = 11'd1439 - row_base - 11'(c_q);
    text_on_d = in_box_q & shadow[bit_idx] & vis;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      text_on    <= 1'b0;
      text_valid <= 1'b0;
    end else begin
      text_on    <= text_on_d;
      text_valid <= pixel_valid_q;
    end
  end

endmodule

// File: tb/tb_header_overlay.sv
// tb/tb_header_overlay.sv - directed self-checking bench for header_overlay
module tb_header_overlay;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [1439:0] pixel_map = '0;
  logic [9:0]    DrawX = '0;
  logic [9:0]    DrawY = '0;
  logic          pixel_valid = 1'b0;
  logic          text_on;
  logic          text_valid;

  int total = 0;
  int bad   = 0;

  header_overlay #(.X0(160), .Y0(16), .SCALE_LOG2(1)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .pixel_map   (pixel_map),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .pixel_valid (pixel_valid),
    .text_on     (text_on),
    .text_valid  (text_valid)
  );

  always #5 Clk = ~Clk;

  task automatic pulse_frame();
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic pixel(input int x, input int y, input logic v,
                       output logic on, output logic val);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    pixel_valid = v;
    @(posedge Clk);
    @(negedge Clk);
    pixel_valid = 1'b0;
    @(posedge Clk);
    #1;
    on  = text_on;
    val = text_valid;
  endtask

  task automatic check_pix(input string name, input int x, input int y, input logic v,
                           input logic exp_on, input logic exp_val);
    logic on, val;
    pixel(x, y, v, on, val);
    total++;
    if (on !== exp_on || val !== exp_val) begin
      bad++;
      $display("FAIL %s (%0d,%0d): text_on=%b text_valid=%b expected %b %b",
               name, x, y, on, val, exp_on, exp_val);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    pixel_valid = 1'b1;
    DrawX = 10'd160;
    DrawY = 10'd16;
    pixel_map = '1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      total++;
      if (text_on !== 1'b0 || text_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: text_on=%b text_valid=%b expected 0 0", text_on, text_valid);
      end
    end
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    total++;
    if (text_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_1: text_valid=%b expected 0", text_valid);
    end
    @(posedge Clk);
    #1;
    total++;
    if (text_valid !== 1'b1 || text_on !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_2: text_on=%b text_valid=%b expected 0 1", text_on, text_valid);
    end
    @(negedge Clk);
    pixel_valid = 1'b0;
    pixel_map = '0;
  endtask

  task automatic test_single_bit();
    pixel_map = '0;
    pixel_map[1439] = 1'b1;
    pulse_frame();
    check_pix("first_bit_a", 160, 16, 1'b1, 1'b1, 1'b1);
    check_pix("first_bit_b", 161, 17, 1'b1, 1'b1, 1'b1);
    check_pix("first_bit_c", 162, 16, 1'b1, 1'b0, 1'b1);
    check_pix("first_bit_d", 159, 16, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_last_bit();
    pixel_map = '0;
    pixel_map[0] = 1'b1;
    pulse_frame();
    check_pix("last_bit_a", 399, 39, 1'b1, 1'b1, 1'b1);
    check_pix("last_bit_b", 400, 39, 1'b1, 1'b0, 1'b1);
    check_pix("last_bit_c", 399, 40, 1'b1, 1'b0, 1'b1);
    check_pix("last_bit_d", 398, 38, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_boundaries();
    pixel_map = '1;
    pulse_frame();
    check_pix("edge_left_in",    160, 20, 1'b1, 1'b1, 1'b1);
    check_pix("edge_left_out",   159, 20, 1'b1, 1'b0, 1'b1);
    check_pix("edge_right_in",   399, 20, 1'b1, 1'b1, 1'b1);
    check_pix("edge_right_out",  400, 20, 1'b1, 1'b0, 1'b1);
    check_pix("edge_top_in",     200, 16, 1'b1, 1'b1, 1'b1);
    check_pix("edge_top_out",    200, 15, 1'b1, 1'b0, 1'b1);
    check_pix("edge_bottom_in",  200, 39, 1'b1, 1'b1, 1'b1);
    check_pix("edge_bottom_out", 200, 40, 1'b1, 1'b0, 1'b1);
    check_pix("far_corner",      639, 479, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_blanking();
    check_pix("blank_in_box", 200, 20, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_frame_latch();
    pixel_map = '1;
    pulse_frame();
    pixel_map = '0;
    check_pix("latch_hold", 220, 25, 1'b1, 1'b1, 1'b1);
    @(negedge Clk);
    DrawX = 10'd220;
    DrawY = 10'd25;
    pixel_valid = 1'b1;
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    @(posedge Clk);
    #1;
    total++;
    if (text_on !== 1'b0 || text_valid !== 1'b1) begin
      bad++;
      $display("FAIL latch_same_cycle: text_on=%b text_valid=%b expected 0 1", text_on, text_valid);
    end
  endtask

  // Streams one pixel per cycle; only r=5, c=60 (bit 779) is lit: x 280..281, y 26..27.
  task automatic test_back_to_back();
    int   xs [8] = '{278, 279, 280, 281, 282, 283, 280, 280};
    int   ys [8] = '{26, 26, 26, 26, 27, 27, 27, 28};
    logic exp [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    pixel_map = '0;
    pixel_map[779] = 1'b1;
    pulse_frame();
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (k >= 2) begin
        total++;
        if (text_on !== exp[k-2] || text_valid !== 1'b1) begin
          bad++;
          $display("FAIL stream_%0d (%0d,%0d): text_on=%b text_valid=%b expected %b 1",
                   k - 2, xs[k-2], ys[k-2], text_on, text_valid, exp[k-2]);
        end
      end
      if (k < 8) begin
        DrawX = 10'(xs[k]);
        DrawY = 10'(ys[k]);
        pixel_valid = 1'b1;
      end else begin
        pixel_valid = 1'b0;
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    pixel_map = '1;
    pulse_frame();
    check_pix("pre_reset_lit", 200, 20, 1'b1, 1'b1, 1'b1);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    check_pix("post_reset_dark", 200, 20, 1'b1, 1'b0, 1'b1);
    pulse_frame();
    check_pix("post_reset_relit", 200, 20, 1'b1, 1'b1, 1'b1);
  endtask

`ifdef OVERLAY_BLINK_EN
  task automatic test_blink();
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    pixel_map = '1;
    for (int f = 1; f <= 64; f++) begin
      pulse_frame();
      check_pix($sformatf("blink_frame_%0d", f), 160, 16, 1'b1,
                ((f % 64) < 32) ? 1'b1 : 1'b0, 1'b1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_bit();
    test_last_bit();
    test_boundaries();
    test_blanking();
    test_frame_latch();
    test_back_to_back();
    test_mid_frame_reset();
`ifdef OVERLAY_BLINK_EN
    test_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, expected finish before 500000");
    $fatal(1);
  end

endmodule
